mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, directly upstream of the writeback mux.
- Takes the EX/MEM address, store data and load/store control, and runs a req/gnt/rvalid transaction on the data-memory bus.
- Generates byte strobes, aligns and sign/zero-extends load data, and produces mem_rdata for the writeback mux's memory input.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): datapath width; only 32 is supported.
- ADDR_WIDTH, 32: byte-address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX/MEM slot holds a valid instruction
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store
- in_funct3  in  3  access size and sign (RV32I encoding)
- in_addr  in  ADDR_WIDTH  effective address (ALU result)
- in_wdata  in  DATA_WIDTH  store data (rs2)
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  word-aligned address, low two bits always 0
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_wstrb  out  4  byte strobes; 0000 on reads
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_WIDTH  read word
- mem_rdata  out  DATA_WIDTH  aligned, extended load result for writeback
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- mem_misalign  out  1  misaligned-access exception pulse

Behaviour:
- Reset: state IDLE. dmem_req, dmem_we, mem_stall and mem_misalign are 0. dmem_addr, dmem_wdata, dmem_wstrb and mem_rdata are 0.
- An access is in_valid AND (in_mem_read OR in_mem_write). Read and write both high is illegal; read takes priority.
- IDLE:
  - Non-access slot: mem_stall is 0.
  - Access: mem_stall is 1 combinationally. Latch address, strobes, data, funct3 and we. Go to REQ.
- REQ:
  - dmem_req is 1 and all bus outputs are stable until dmem_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - dmem_rvalid in REQ is ignored.
- WAIT: on dmem_rvalid, register the aligned/extended data into mem_rdata and go to DONE.
- DONE:
  - mem_stall is 0 for exactly one cycle, so the pipeline advances.
  - mem_rdata is held until the next load completes.
  - Return to IDLE.
- mem_stall is 1 in IDLE-with-access, REQ and WAIT.
- Minimum latency:
  - Load: 3 stall cycles (gnt on the first REQ cycle, rvalid on the next cycle).
  - Store: 2 stall cycles.
- No timeout exists; a bus that never grants stalls the pipeline indefinitely.
- Store strobe generation:
  - SB: 0001 << a[1:0], data {4{wdata[7:0]}}.
  - SH: 0011 << {a[1],1'b0}, data {2{wdata[15:0]}}.
  - SW: 1111, data wdata.
- Load extraction: shift the word right by a[1:0]*8.
  - LB: sign-extend byte. LBU: zero-extend byte.
  - LH: sign-extend half. LHU: zero-extend half.
  - LW: whole word.
  - Unused funct3 codes are treated as LW/SW.
- Reset mid-transaction returns to IDLE next edge, drops dmem_req immediately, and discards any late rvalid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means a half access with a[0]=1, or a word access with a[1:0]≠0.
- With the macro:
  - A misaligned access issues no bus request.
  - mem_misalign pulses 1 for one cycle in IDLE, with mem_stall 0.
  - mem_rdata is unchanged.
  - State stays IDLE.
- Without the macro:
  - mem_misalign is tied to 0.
  - Offending low address bits are masked: a[0] for half accesses, a[1:0] for word accesses.
  - The access then proceeds normally.

Decomposition:
- Defines.vh: `DATA_WIDTH plus new constants:
  - funct3 codes: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encodings: LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE.
- One sub-module: lsu_load_align. It is combinational: word + offset + funct3 → extended result.

Test Plan:
- SW to 0x100 of 0xDEADBEEF, gnt in the first REQ cycle → dmem_wstrb 1111, dmem_addr 0x100; 2 stall cycles.
- SB to 0x103 of 0x000000A5 → wstrb 1000, dmem_wdata 0xA5A5A5A5, dmem_addr 0x100.
- Load sign/zero extension with dmem_rdata 0x80FF7F01:
  - LB @0x102 → mem_rdata 0xFFFFFFFF.
  - LBU @0x103 → 0x00000080.
  - LH @0x102 → 0xFFFF80FF.
  - LW → 0x80FF7F01.
- gnt delayed 3 cycles and rvalid 2 cycles after gnt → dmem_req and bus outputs held stable; mem_stall 1 for 6 cycles, then 0 for exactly one cycle.
- rst asserted in WAIT → next cycle state IDLE, dmem_req 0, mem_stall 0; a subsequent rvalid does not change mem_rdata.
- LW @0x102:
  - With LSU_MISALIGN_TRAP_EN: mem_misalign 1 for one cycle, no dmem_req.
  - Without it: dmem_addr 0x100 and a normal read.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the memory-access stage: funct3 codes, FSM states and the access-size decode.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Stores have no unsigned variants, so BU/HU codes fall back to word width there.
  function automatic lsu_size_e access_size(input logic [2:0] f3, input logic is_store);
    lsu_size_e sz;
    case (f3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_BU:   sz = is_store ? SZ_W : SZ_B;
      F3_HU:   sz = is_store ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load extractor: shifts the bus word to the addressed lane and sign/zero-extends it.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  logic [DATA_WIDTH-1:0] shifted_s;

  // Lane shift then extension by access type
  always_comb begin
    shifted_s = word_i >> {offset_i, 3'b000};
    result_o  = shifted_s;
    case (funct3_i)
      F3_B:    result_o = {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   result_o = {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]};
      F3_H:    result_o = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   result_o = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
      default: result_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit driving a req/gnt/rvalid data bus and stalling the pipeline while busy.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses raise mem_misalign instead of being address-masked.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_stall,
  output logic                  mem_misalign
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  access_s;
  logic                  is_store_s;
  lsu_size_e             size_s;
  logic [1:0]            off_s;
  logic [3:0]            strb_s;
  logic [DATA_WIDTH-1:0] wrep_s;
  logic                  trap_s;
  logic                  stall_s;
  logic                  misalign_s;
  logic [DATA_WIDTH-1:0] align_s;

  assign access_s   = in_valid & (in_mem_read | in_mem_write);
  assign is_store_s = in_mem_write & ~in_mem_read;
  assign size_s     = access_size(in_funct3, is_store_s);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s = ((size_s == SZ_H) & in_addr[0]) |
                  ((size_s == SZ_W) & (in_addr[1:0] != 2'b00));
`else
  assign trap_s = 1'b0;
`endif

  // Lane offset with low bits below the access size masked, plus strobes and replicated store data
  always_comb begin
    off_s  = 2'b00;
    strb_s = 4'b1111;
    wrep_s = in_wdata;
    case (size_s)
      SZ_B: begin
        off_s  = in_addr[1:0];
        strb_s = 4'b0001 << in_addr[1:0];
        wrep_s = {4{in_wdata[7:0]}};
      end
      SZ_H: begin
        off_s  = {in_addr[1], 1'b0};
        strb_s = 4'b0011 << {in_addr[1], 1'b0};
        wrep_s = {2{in_wdata[15:0]}};
      end
      default: begin
        off_s  = 2'b00;
        strb_s = 4'b1111;
        wrep_s = in_wdata;
      end
    endcase
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .word_i   (dmem_rdata),
    .offset_i (off_q),
    .funct3_i (funct3_q),
    .result_o (align_s)
  );

  // Next-state and stall/trap decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    stall_s    = 1'b0;
    misalign_s = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (access_s && trap_s) begin
          misalign_s = 1'b1;
        end else if (access_s) begin
          stall_s  = 1'b1;
          addr_d   = {in_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d  = wrep_s;
          wstrb_d  = is_store_s ? strb_s : 4'b0000;
          we_d     = is_store_s;
          funct3_d = in_funct3;
          off_d    = off_s;
          state_d  = LSU_REQ;
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        stall_s = 1'b1;
        if (dmem_gnt) begin
          state_d = we_q ? LSU_DONE : LSU_WAIT;
        end else begin
          state_d = LSU_REQ;
        end
      end
      LSU_WAIT: begin
        stall_s = 1'b1;
        if (dmem_rvalid) begin
          rdata_d = align_s;
          state_d = LSU_DONE;
        end else begin
          state_d = LSU_WAIT;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and latched bus fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LSU_IDLE;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q  <= {DATA_WIDTH{1'b0}};
      wstrb_q  <= 4'b0000;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
    end
  end

  // Reset masks the request and stall in the same cycle it is raised
  assign dmem_req     = (state_q == LSU_REQ) & ~rst;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign mem_rdata    = rdata_q;
  assign mem_stall    = stall_s & ~rst;
  assign mem_misalign = misalign_s & ~rst;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus randomized bench for mem_stage_lsu with a transaction-level reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_rdata;
  logic        mem_stall, mem_misalign;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Access size in bytes from the RV32I funct3 rules
  function automatic int size_of(input bit ld, input logic [2:0] f3);
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    if (ld && f3 == 3'd4) return 1;
    if (ld && f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input int off, input logic [2:0] f3);
    logic [31:0] sh;
    logic [31:0] b, h;
    sh = word >> (8 * off);
    b  = sh & 32'h0000_00FF;
    h  = sh & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return sh;
    endcase
  endfunction

  // One complete access: slot presented in IDLE, gl REQ cycles without grant, rl WAIT cycles without rvalid
  task automatic access(input bit ld, input bit both, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int gl, input int rl);
    int          s, off, stalls;
    bit          trap;
    logic [3:0]  estrb;
    logic [31:0] ewd, eaddr;
    s      = size_of(ld, f3);
    off    = int'(a % 4) - (int'(a % 4) % s);
    trap   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap   = (a % s) != 0;
`endif
    estrb  = (s == 1) ? (4'b0001 << off) : (s == 2) ? (4'b0011 << off) : 4'b1111;
    ewd    = (s == 1) ? {4{wd[7:0]}} : (s == 2) ? {2{wd[15:0]}} : wd;
    eaddr  = a & 32'hFFFF_FFFC;
    @(negedge clk);
    in_valid = 1'b1; in_mem_read = ld; in_mem_write = !ld || both;
    in_funct3 = f3; in_addr = a; in_wdata = wd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    if (trap) begin
      chk("trap_misalign", mem_misalign, 1);
      chk("trap_stall", mem_stall, 0);
      chk("trap_req", dmem_req, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("trap_after_req", dmem_req, 0);
      chk("trap_after_misalign", mem_misalign, 0);
      chk("trap_rdata", mem_rdata, exp_rdata);
      return;
    end
    chk("idle_stall", mem_stall, 1);
    chk("idle_req", dmem_req, 0);
    chk("idle_misalign", mem_misalign, 0);
    stalls = 1;
    for (int k = 0; k <= gl; k++) begin
      @(negedge clk);
      dmem_gnt    = (k == gl);
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
      #1;
      chk("req_req", dmem_req, 1);
      chk("req_we", dmem_we, !ld);
      chk("req_addr", dmem_addr, eaddr);
      chk("req_wstrb", dmem_wstrb, ld ? 4'b0000 : estrb);
      if (!ld) chk("req_wdata", dmem_wdata, ewd);
      stalls += mem_stall;
    end
    if (ld) begin
      for (int j = 0; j <= rl; j++) begin
        @(negedge clk);
        dmem_gnt    = 1'b0;
        dmem_rvalid = (j == rl);
        dmem_rdata  = (j == rl) ? rd : $urandom;
        #1;
        chk("wait_req", dmem_req, 0);
        chk("wait_rdata_held", mem_rdata, exp_rdata);
        stalls += mem_stall;
      end
      exp_rdata = load_val(rd, off, f3);
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; in_valid = 1'b0;
    #1;
    chk("done_stall", mem_stall, 0);
    chk("done_req", dmem_req, 0);
    chk("done_rdata", mem_rdata, exp_rdata);
    chk("stall_cycles", stalls, 1 + (gl + 1) + (ld ? (rl + 1) : 0));
  endtask

  task automatic idle_slot(input bit v, input bit rd, input bit wr);
    @(negedge clk);
    in_valid = v; in_mem_read = rd; in_mem_write = wr;
    #1;
    chk("noacc_stall", mem_stall, 0);
    chk("noacc_req", dmem_req, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("noacc_req_next", dmem_req, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_funct3 = 3'd0; in_addr = 32'h0; in_wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_misalign", mem_misalign, 0);
    rst = 1'b0;

    access(1'b0, 1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    access(1'b0, 1'b0, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    access(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h80FF7F01, 0, 0);
    chk("plan_lb", mem_rdata, 32'hFFFFFFFF);
    access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF7F01, 0, 0);
    chk("plan_lbu", mem_rdata, 32'h00000080);
    access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF7F01, 0, 0);
    chk("plan_lh", mem_rdata, 32'hFFFF80FF);
    access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h80FF7F01, 0, 0);
    chk("plan_lw", mem_rdata, 32'h80FF7F01);
    access(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 32'h13572468, 2, 1);
    access(1'b0, 1'b0, 3'd1, 32'h10A, 32'h0000BEEF, 32'h0, 1, 0);
    access(1'b1, 1'b1, 3'd5, 32'h10E, 32'h0, 32'h8001C0DE, 0, 2);
    access(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h55AA33CC, 0, 0);
    idle_slot(1'b1, 1'b0, 1'b0);
    idle_slot(1'b0, 1'b1, 1'b1);

    // Reset during REQ: request drops in the same cycle
    @(negedge clk);
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'd2; in_addr = 32'h200;
    @(negedge clk);
    #1;
    chk("rreq_req_before", dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("rreq_req_drop", dmem_req, 0);
    chk("rreq_stall", mem_stall, 0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rreq_idle_req", dmem_req, 0);
    chk("rreq_idle_stall", mem_stall, 0);

    // Reset during WAIT: late rvalid must be discarded
    access(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'd2; in_addr = 32'h304;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; rst = 1'b1;
    exp_rdata = 32'h0;
    #1;
    chk("rwait_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("rwait_req", dmem_req, 0);
    chk("rwait_stall_idle", mem_stall, 0);
    chk("rwait_rdata_cleared", mem_rdata, 32'h0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk("rwait_late_rvalid", mem_rdata, exp_rdata);
    chk("rwait_req_after", dmem_req, 0);

    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
             32'h400 + 32'($urandom_range(0, 255)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
